// File: rtl/avs_uart_tx.sv
// Avalon-MM UART transmitter: 4-register slave, byte FIFO, 8N1/8P1/8N2/8P2 framing, TX-empty irq.
// Latency: every bus access takes 2 cycles; a push reaches the FIFO 1 cycle after accept, tx falls 2 cycles after accept.
// Backpressure: waitrequest stalls each command for one cycle; pushes into a full FIFO are dropped and flagged in OVF.

// Generic synchronous FIFO with flush; a full FIFO still accepts a write when a read happens in the same cycle.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  output logic                     wr_rdy,
  output logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  input  logic                     rd_rdy,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign rd_vld  = (cnt != '0);
  assign do_pop  = rd_rdy & rd_vld;
  assign wr_rdy  = ~full | do_pop;
  assign do_push = wr_vld & wr_rdy;
  assign rd_dat  = mem[rd_ptr];
  assign level   = cnt;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module avs_uart_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        avs_s0_waitrequest,
  output logic        avs_s0_irq,
  output logic        avs_s0_export_tx
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CLKDIV  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Bus handshake and register file
  logic        ack;
  logic        cmd;
  logic        wr_acc;
  logic [31:0] readdata_q;
  logic [31:0] rd_mux;
  logic        ctrl_tx_en;
  logic        ctrl_irq_en;
  logic        ctrl_par_en;
  logic        ctrl_par_odd;
  logic        ctrl_stop2;
  logic [15:0] clk_div_q;
  logic        ovf;

  // FIFO hookup
  logic          push_req;
  logic          flush;
  logic          fifo_wr_rdy;
  logic          fifo_rd_vld;
  logic [7:0]    fifo_rd_dat;
  logic [LW-1:0] fifo_level;
  logic [8:0]    level9;
  logic          fifo_full;
  logic          fifo_empty;

  // Transmitter
  tx_state_t   state;
  tx_state_t   state_nxt;
  logic        pop;
  logic        tx_nxt;
  logic        bit_end;
  logic        busy;
  logic [15:0] baud_cnt;
  logic [15:0] lat_div;
  logic        lat_par_en;
  logic        lat_stop2;
  logic        par_bit;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        stop_second;
  logic        tx_q;

  logic        unused_bits;

  assign cmd    = avs_s0_read | avs_s0_write;
  assign wr_acc = avs_s0_write & ack;

  assign avs_s0_waitrequest = cmd & ~ack;
  assign avs_s0_readdata    = readdata_q;
  assign avs_s0_export_tx   = tx_q;

  assign push_req = wr_acc && (avs_s0_address == ADDR_TXDATA);
  assign flush    = wr_acc && (avs_s0_address == ADDR_CONTROL) && avs_s0_writedata[2];

  assign level9     = 9'(fifo_level);
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = ~fifo_rd_vld;
  assign busy       = (state != ST_IDLE);

  assign avs_s0_irq = ctrl_irq_en & fifo_empty & ~busy;

  assign unused_bits = ^{avs_s0_writedata[31:16], level9[8]};

  uart_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .wr_vld (push_req),
    .wr_dat (avs_s0_writedata[7:0]),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (fifo_rd_vld),
    .rd_dat (fifo_rd_dat),
    .rd_rdy (pop),
    .level  (fifo_level)
  );

  // Read-data source for the addressed register.
  always_comb begin
    rd_mux = 32'd0;
    case (avs_s0_address)
      ADDR_CONTROL: rd_mux = {26'd0, ctrl_stop2, ctrl_par_odd, ctrl_par_en, 1'b0, ctrl_irq_en, ctrl_tx_en};
      ADDR_STATUS:  rd_mux = {16'd0, level9[7:0], 4'd0, ovf, busy, fifo_full, fifo_empty};
      ADDR_CLKDIV:  rd_mux = {16'd0, clk_div_q};
      default:      rd_mux = 32'd0;
    endcase
  end

  // Ack pulse gives each command one wait cycle; readdata is captured in the wait cycle so it is valid on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack        <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      ack <= cmd & ~ack;
      if (avs_s0_read && !ack) readdata_q <= avs_s0_write ? 32'd0 : rd_mux;
    end
  end

  // Writable registers commit on the accept cycle; OVF is sticky until cleared through STATUS.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_tx_en   <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      ctrl_par_en  <= 1'b0;
      ctrl_par_odd <= 1'b0;
      ctrl_stop2   <= 1'b0;
      clk_div_q    <= DEFAULT_DIV;
      ovf          <= 1'b0;
    end else begin
      if (wr_acc && avs_s0_address == ADDR_CONTROL) begin
        ctrl_tx_en   <= avs_s0_writedata[0];
        ctrl_irq_en  <= avs_s0_writedata[1];
        ctrl_par_en  <= avs_s0_writedata[3];
        ctrl_par_odd <= avs_s0_writedata[4];
        ctrl_stop2   <= avs_s0_writedata[5];
      end
      if (wr_acc && avs_s0_address == ADDR_CLKDIV) clk_div_q <= avs_s0_writedata[15:0];
      if (push_req && !fifo_wr_rdy) begin
        ovf <= 1'b1;
      end else if (wr_acc && avs_s0_address == ADDR_STATUS && avs_s0_writedata[3]) begin
        ovf <= 1'b0;
      end
    end
  end

  // Transmitter state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state, pop request and the line level belonging to the current state.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    bit_end   = (baud_cnt == 16'd0);
    case (state)
      ST_IDLE: begin
        if (ctrl_tx_en && fifo_rd_vld) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx_nxt = 1'b0;
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx_nxt = shreg[0];
        if (bit_end && bit_idx == 3'd7) state_nxt = lat_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx_nxt = par_bit;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        tx_nxt = 1'b1;
        if (bit_end && (!lat_stop2 || stop_second)) begin
          // Chain straight into the next frame so there is no idle gap.
          if (ctrl_tx_en && fifo_rd_vld) begin
            pop       = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: per-frame config latch, baud countdown, data shifter and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt    <= 16'd0;
      lat_div     <= 16'd0;
      lat_par_en  <= 1'b0;
      lat_stop2   <= 1'b0;
      par_bit     <= 1'b0;
      shreg       <= 8'd0;
      bit_idx     <= 3'd0;
      stop_second <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      tx_q <= tx_nxt;
      if (pop) begin
        shreg       <= fifo_rd_dat;
        par_bit     <= (^fifo_rd_dat) ^ ctrl_par_odd;
        lat_par_en  <= ctrl_par_en;
        lat_stop2   <= ctrl_stop2;
        lat_div     <= clk_div_q;
        baud_cnt    <= clk_div_q;
        bit_idx     <= 3'd0;
        stop_second <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (bit_end) begin
          baud_cnt <= lat_div;
          if (state == ST_DATA) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          if (state == ST_STOP) stop_second <= ~stop_second;
        end else begin
          baud_cnt <= baud_cnt - 16'd1;
        end
      end
    end
  end
endmodule

// File: doc/avs_uart_tx.md
# avs_uart_tx

Avalon-MM slave UART transmitter with a byte FIFO, programmable baud divider, optional parity/2-stop framing and a TX-empty interrupt. It is the responder that Avalon-MM masters and bench read/write tasks target via the address/read/write/waitrequest handshake. It drives the serial TX pin exported to the board.

## Interface
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DEFAULT_DIV, 16'd433, reset value of CLK_DIV; bit period = CLK_DIV+1 clocks.
- clk  in  1  sole clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- avs_s0_address  in  2  word address: 0 TXDATA, 1 CONTROL, 2 STATUS, 3 CLK_DIV.
- avs_s0_read  in  1  read request.
- avs_s0_write  in  1  write request.
- avs_s0_writedata  in  32  write data.
- avs_s0_readdata  out  32  read data; valid in the cycle waitrequest is low with read high.
- avs_s0_waitrequest  out  1  stall; master holds address/command while high.
- avs_s0_irq  out  1  level interrupt.
- avs_s0_export_tx  out  1  serial output; idle high.

## Operation
- Register map:
  - TXDATA (W): bits[7:0] pushed into the FIFO. Reads return 0.
  - CONTROL (RW, reset 0):
    - bit0 TX_EN.
    - bit1 IRQ_EMPTY_EN.
    - bit2 FLUSH: write-only, self-clearing, always reads 0.
    - bit3 PAR_EN.
    - bit4 PAR_ODD.
    - bit5 STOP2.
  - STATUS (R): bit0 EMPTY, bit1 FULL, bit2 BUSY (frame in progress), bit3 OVF (sticky), bits[15:8] FIFO level. Writing STATUS with bit3=1 clears OVF; other bits are ignored.
  - CLK_DIV (RW): bits[15:0]. Upper bits read 0.
- Push to TXDATA when FULL: byte dropped, OVF set, FIFO unchanged.
- Transmitter FSM: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
  - IDLE: when TX_EN=1 and FIFO not empty, pop the head byte, latch PAR_EN/PAR_ODD/STOP2/CLK_DIV, and go to START.
  - START: tx=0 for one bit period.
  - DATA: 8 bits, LSB first. 3-bit bit index 0..7.
  - PARITY: even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: tx=1 for one bit period, or two if STOP2.
  - From STOP, return to IDLE. Back-to-back frames have no idle gap: the next pop happens in the cycle STOP ends.
- Baud counter: 16-bit, loads the latched CLK_DIV at each bit start and counts down to 0. Bit ends when it reaches 0. CLK_DIV=0 gives 1 clock per bit.
- CLK_DIV or CONTROL writes mid-frame affect the next frame only.
- Clearing TX_EN mid-frame: the current frame completes; no further pops.
- FLUSH: FIFO is emptied in the cycle after the write. A frame in progress completes. A push in the same transaction is impossible (different address).
- Simultaneous push and pop: both occur; level unchanged; a full FIFO still accepts the push.
- irq = IRQ_EMPTY_EN & EMPTY & ~BUSY (combinational from registers).

## Timing
- Each read or write takes exactly 2 cycles:
  - Cycle 1: waitrequest=1.
  - Cycle 2: waitrequest=0, the action commits, and readdata is driven.
  - waitrequest is low when read=write=0.
- The 2-cycle rule is implemented with a registered ack pulse. waitrequest = (read|write) & ~ack. ack clears after the accept cycle, so back-to-back commands each take 2 cycles.
- read and write high together: write takes priority; readdata=0.
- readdata is registered and holds its value until the next accepted read; reset value 0.
- Push latency:
  - Write accepted at edge N: FIFO level and EMPTY update at N+1.
  - FSM in IDLE with TX_EN=1 pops at N+1.
  - tx falls at N+2.
- Frame length in clocks = (CLK_DIV+1) × (10 + PAR_EN + STOP2).
- Reset values: tx=1, waitrequest=0, readdata=0, irq=0. Also FSM=IDLE, FIFO empty, OVF=0, CONTROL=0, CLK_DIV=DEFAULT_DIV.
- Reset asserted mid-frame: tx is 1 at the next edge, and the FIFO contents are discarded.

## Test plan
- Reset, then read all four registers -> 0, 0, 0x00000001 (EMPTY), DEFAULT_DIV. Each read has exactly 1 waitrequest cycle.
- CLK_DIV=3, CONTROL=0x1, write TXDATA=0x55 -> tx falls 2 clocks after accept. Pattern 0,1,0,1,0,1,0,1,0,1, 4 clocks per bit, 40 clocks total. irq stays 0.
- CLK_DIV=1, CONTROL=0x0B (PAR_EN, IRQ_EMPTY_EN, TX_EN), send 0x07 -> parity bit 1, frame 22 clocks. irq rises when the stop bit ends.
- CONTROL=0, push FIFO_DEPTH+1 bytes -> STATUS reads FULL=1, OVF=1, level=FIFO_DEPTH. Write STATUS=0x8 -> OVF=0. Write CONTROL=0x4 -> EMPTY=1.
- CLK_DIV=0, push 0xA5, 0x3C, then set TX_EN -> two frames back to back, 20 clocks with no idle gap, bytes in order.
- Assert reset in data bit 4 of a frame -> tx=1 at the next edge, STATUS=0x1, no further transmission.
